// File: rtl/config_loader_pkg.sv
// +----------------------------------------------------------------------+
// | config_loader_pkg: opcodes, FSM states and default sync word shared  |
// | by the configuration frame loader.            Revision: 1.0          |
// +----------------------------------------------------------------------+
`default_nettype none

package config_loader_pkg;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_END   = 8'h0F;

  localparam logic [31:0] DEFAULT_SYNC_WORD = 32'hFAB0_FAB1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    DATA   = 3'd2,
    DROP   = 3'd3,
    SETUP  = 3'd4,
    STROBE = 3'd5,
    HOLD   = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/frame_strobe_decode.sv
// +----------------------------------------------------------------------+
// | frame_strobe_decode: registered one-hot decode of (col, frame, en)   |
// | onto the column/frame write strobe.           Revision: 1.0          |
// +----------------------------------------------------------------------+
`default_nettype none

module frame_strobe_decode #(
  parameter int NUM_COLS       = 16,
  parameter int FRAMES_PER_COL = 20
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [7:0]                         col,
  input  logic [7:0]                         frame,
  input  logic                               en,
  output logic [NUM_COLS*FRAMES_PER_COL-1:0] strobe
);

  logic [NUM_COLS*FRAMES_PER_COL-1:0] hit;

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    for (genvar f = 0; f < FRAMES_PER_COL; f++) begin : g_frame
      assign hit[c*FRAMES_PER_COL+f] = (col == 8'(c)) && (frame == 8'(f));
    end
  end

  // Registered so the strobe can never glitch while col/frame settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe <= '0;
    end else begin
      strobe <= en ? hit : '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/config_frame_loader.sv
// +----------------------------------------------------------------------+
// | config_frame_loader: assembles NUM_ROWS-word frames from a bitstream |
// | word stream and strobes them into the fabric.  Revision: 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

module config_frame_loader
  import config_loader_pkg::*;
#(
  parameter int          NUM_ROWS       = 8,
  parameter int          NUM_COLS       = 16,
  parameter int          FRAMES_PER_COL = 20,
  parameter logic [31:0] SYNC_WORD      = DEFAULT_SYNC_WORD
) (
  input  logic                               CLK,
  input  logic                               resetn,
  input  logic [31:0]                        s_data_i,
  input  logic                               s_valid_i,
  output logic                               s_ready_o,
  output logic [32*NUM_ROWS-1:0]             FrameData_o,
  output logic [NUM_COLS*FRAMES_PER_COL-1:0] FrameStrobe_o,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               err_o,
  output logic [15:0]                        frame_cnt_o
);

  localparam int               ROW_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

  state_t           state;
  state_t           next_state;
  logic [ROW_W-1:0] row;
  logic [7:0]       col;
  logic [7:0]       frame;
  logic             accept;
  logic             xfer;
  logic [7:0]       opcode;
  logic             addr_ok;
  logic             load_cmd;
  logic             set_err;
  logic             set_done;
  logic             clr_stat;

  always_comb accept = state inside {IDLE, CMD, DATA, DROP};

  // Gated by resetn so the port reads 0 for the whole reset assertion.
  assign s_ready_o = accept & resetn;
  assign xfer      = s_valid_i & s_ready_o;
  assign opcode    = s_data_i[31:24];
  assign addr_ok   = ({24'd0, s_data_i[23:16]} < NUM_COLS) &&
                     ({24'd0, s_data_i[15:8]} < FRAMES_PER_COL);
  assign busy_o    = (state != IDLE);

  always_comb begin
    next_state = state;
    load_cmd   = 1'b0;
    set_err    = 1'b0;
    set_done   = 1'b0;
    clr_stat   = 1'b0;
    case (state)
      IDLE: begin
        if (xfer && (s_data_i == SYNC_WORD)) begin
          clr_stat   = 1'b1;
          next_state = CMD;
        end
      end
      CMD: begin
        if (xfer) begin
          case (opcode)
            OP_WRITE: begin
              load_cmd = 1'b1;
              if (addr_ok) begin
                next_state = DATA;
              end else begin
                set_err    = 1'b1;
                next_state = DROP;
              end
            end
            OP_END: begin
              set_done   = 1'b1;
              next_state = IDLE;
            end
            OP_NOP:  next_state = CMD;
            default: begin
              set_err    = 1'b1;
              next_state = IDLE;
            end
          endcase
        end
      end
      DATA:    if (xfer && (row == LAST_ROW)) next_state = SETUP;
      DROP:    if (xfer && (row == LAST_ROW)) next_state = CMD;
      SETUP:   next_state = STROBE;
      STROBE:  next_state = HOLD;
      HOLD:    next_state = CMD;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      row         <= '0;
      col         <= '0;
      frame       <= '0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      frame_cnt_o <= '0;
    end else begin
      done_o <= set_done;

      if (clr_stat) begin
        err_o <= 1'b0;
      end else if (set_err) begin
        err_o <= 1'b1;
      end

      if (clr_stat) begin
        frame_cnt_o <= '0;
      end else if ((state == STROBE) && (frame_cnt_o != 16'hFFFF)) begin
        frame_cnt_o <= frame_cnt_o + 16'd1;
      end

      if (load_cmd) begin
        col   <= s_data_i[23:16];
        frame <= s_data_i[15:8];
        row   <= '0;
      end else if (xfer && ((state == DATA) || (state == DROP))) begin
        row <= (row == LAST_ROW) ? '0 : row + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      FrameData_o <= '0;
    end else if (xfer && (state == DATA)) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (row == ROW_W'(r)) begin
          FrameData_o[32*r +: 32] <= s_data_i;
        end
      end
    end
  end

  // Enabled in SETUP so the registered strobe lands in the STROBE cycle.
  frame_strobe_decode #(
    .NUM_COLS       (NUM_COLS),
    .FRAMES_PER_COL (FRAMES_PER_COL)
  ) u_strobe_decode (
    .clk    (CLK),
    .rst_n  (resetn),
    .col    (col),
    .frame  (frame),
    .en     (state == SETUP),
    .strobe (FrameStrobe_o)
  );

endmodule

`default_nettype wire
